// File: rtl/mem_bus_pkg.sv
// Shared types for the two-master memory arbiter: FSM states, grant owner and op kind.
// Also carries the default bus widths and a small helper for the owner-exclusion mask.
package mem_bus_pkg;

   localparam int unsigned AW_DEF = 16;
   localparam int unsigned DW_DEF = 16;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;
   typedef enum logic {GNT_I, GNT_D} gnt_t;
   typedef enum logic {OP_RD, OP_WR} op_t;

   // Bit 0 masks the fetch port, bit 1 masks the data port.
   function automatic logic [1:0] excl_mask(gnt_t g);
      return (g == GNT_I) ? 2'b01 : 2'b10;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way picker: round-robin against last_gnt, or fixed data priority.
// Requests flagged in excl are ignored so the current owner can be skipped.
module rr_arb2
   import mem_bus_pkg::*;
#(
   parameter bit DPRIO = 1'b0
) (
   input  logic       i_req,
   input  logic       d_req,
   input  gnt_t       last_gnt,
   input  logic [1:0] excl,
   output logic       gnt_valid,
   output gnt_t       gnt
);

   logic ri, rd;

   assign ri = i_req & ~excl[0];
   assign rd = d_req & ~excl[1];
   assign gnt_valid = ri | rd;

   always_comb begin
      gnt = GNT_I;
      if (ri && rd) begin
         if (DPRIO) begin
            gnt = GNT_D;
         end else if (last_gnt == GNT_I) begin
            gnt = GNT_D;
         end else begin
            gnt = GNT_I;
         end
      end else if (rd) begin
         gnt = GNT_D;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and load/store requests onto one single-port synchronous memory.
// One op at a time: IDLE -> ISSUE (m_* strobe) -> RESP (completion pulse, data pass-through).
module mem_arbiter
   import mem_bus_pkg::*;
#(
   parameter int unsigned AW    = AW_DEF,
   parameter int unsigned DW    = DW_DEF,
   parameter bit          DPRIO = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] i_addr,
   input  logic          i_re,
   output logic [DW-1:0] i_rdata,
   output logic          i_rready,
   input  logic [AW-1:0] d_addr,
   input  logic          d_re,
   input  logic          d_we,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_rready,
   output logic          d_wack,
   output logic [AW-1:0] m_raddr,
   output logic          m_re,
   output logic [AW-1:0] m_waddr,
   output logic [DW-1:0] m_wdata,
   output logic          m_we,
   input  logic [DW-1:0] m_rdata
);

   arb_state_t    state_q, state_d;
   gnt_t          gnt_q, last_gnt_q, gnt_nxt;
   op_t           op_q, op_nxt;
   logic          gnt_valid;
   logic          load;
   logic [1:0]    excl;
   logic [AW-1:0] addr_nxt;

   // The owner still holds its request during RESP, so keep it out of the next pick.
   assign excl = (state_q == RESP) ? excl_mask(gnt_q) : 2'b00;

   rr_arb2 #(
      .DPRIO(DPRIO)
   ) u_pick (
      .i_req    (i_re),
      .d_req    (d_re | d_we),
      .last_gnt (last_gnt_q),
      .excl     (excl),
      .gnt_valid(gnt_valid),
      .gnt      (gnt_nxt)
   );

   // Write wins when the data port asks for both; the read is picked up on a later grant.
   always_comb begin
      op_nxt   = OP_RD;
      addr_nxt = i_addr;
      if (gnt_nxt == GNT_D) begin
         addr_nxt = d_addr;
         if (d_we) begin
            op_nxt = OP_WR;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               state_d = ISSUE;
               load    = 1'b1;
            end
         end
         ISSUE: state_d = RESP;
         RESP: begin
            if (gnt_valid) begin
               state_d = ISSUE;
               load    = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_q      <= GNT_I;
         last_gnt_q <= GNT_D;
         op_q       <= OP_RD;
         m_re       <= 1'b0;
         m_we       <= 1'b0;
         m_raddr    <= '0;
         m_waddr    <= '0;
         m_wdata    <= '0;
      end else begin
         m_re    <= 1'b0;
         m_we    <= 1'b0;
         m_raddr <= '0;
         m_waddr <= '0;
         m_wdata <= '0;
         if (load) begin
            gnt_q      <= gnt_nxt;
            last_gnt_q <= gnt_nxt;
            op_q       <= op_nxt;
            if (op_nxt == OP_WR) begin
               m_we    <= 1'b1;
               m_waddr <= addr_nxt;
               m_wdata <= d_wdata;
            end else begin
               m_re    <= 1'b1;
               m_raddr <= addr_nxt;
            end
         end
      end
   end

   always_comb begin
      i_rready = 1'b0;
      d_rready = 1'b0;
      d_wack   = 1'b0;
      i_rdata  = '0;
      d_rdata  = '0;
      if (state_q == RESP) begin
         i_rdata = m_rdata;
         d_rdata = m_rdata;
         if (gnt_q == GNT_I) begin
            i_rready = 1'b1;
         end else if (op_q == OP_WR) begin
            d_wack = 1'b1;
         end else begin
            d_rready = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory and a completion scoreboard.
// A second instance with DPRIO=1 shares all inputs so tie-breaking can be compared.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] i_addr, d_addr, d_wdata;
   logic        i_re, d_re, d_we;
   logic [15:0] i_rdata, d_rdata, m_raddr, m_waddr, m_wdata, m_rdata;
   logic        i_rready, d_rready, d_wack, m_re, m_we;

   logic [15:0] p_i_rdata, p_d_rdata, p_m_raddr, p_m_waddr, p_m_wdata;
   logic        p_i_rready, p_d_rready, p_d_wack, p_m_re, p_m_we;
   logic [15:0] p_m_rdata;

   logic [15:0] mem [256];

   typedef struct {
      int          kind;  // 0 fetch read, 1 data read, 2 data write
      logic [15:0] data;
   } exp_t;
   exp_t sb[$];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign p_m_rdata = 16'h0000;

   mem_arbiter #(.AW(16), .DW(16), .DPRIO(1'b0)) u_dut (
      .clk(clk), .rst(rst),
      .i_addr(i_addr), .i_re(i_re), .i_rdata(i_rdata), .i_rready(i_rready),
      .d_addr(d_addr), .d_re(d_re), .d_we(d_we), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_rready(d_rready), .d_wack(d_wack),
      .m_raddr(m_raddr), .m_re(m_re), .m_waddr(m_waddr), .m_wdata(m_wdata),
      .m_we(m_we), .m_rdata(m_rdata)
   );

   mem_arbiter #(.AW(16), .DW(16), .DPRIO(1'b1)) u_dut_p (
      .clk(clk), .rst(rst),
      .i_addr(i_addr), .i_re(i_re), .i_rdata(p_i_rdata), .i_rready(p_i_rready),
      .d_addr(d_addr), .d_re(d_re), .d_we(d_we), .d_wdata(d_wdata),
      .d_rdata(p_d_rdata), .d_rready(p_d_rready), .d_wack(p_d_wack),
      .m_raddr(p_m_raddr), .m_re(p_m_re), .m_waddr(p_m_waddr), .m_wdata(p_m_wdata),
      .m_we(p_m_we), .m_rdata(p_m_rdata)
   );

   // Single-port synchronous memory: read data appears the cycle after m_re.
   always @(posedge clk) begin
      if (m_we) mem[m_waddr[7:0]] <= m_wdata;
      if (m_re) m_rdata <= mem[m_raddr[7:0]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int kind, input logic [15:0] data);
      exp_t e;
      e.kind = kind;
      e.data = data;
      sb.push_back(e);
   endtask

   // Completion monitor: every strobe must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         chk("m_re_m_we_exclusive", {31'd0, m_re & m_we}, 32'd0);
         chk("one_strobe", {31'd0, (i_rready & d_rready) | (i_rready & d_wack) |
                            (d_rready & d_wack)}, 32'd0);
         if (i_rready || d_rready || d_wack) begin
            int          okind;
            logic [15:0] odata;
            exp_t        e;
            okind = i_rready ? 0 : (d_rready ? 1 : 2);
            odata = i_rready ? i_rdata : d_rdata;
            n_cmp++;
            assert (sb.size() != 0)
            else begin
               n_err++;
               $error("FAIL unexpected_strobe: observed kind %0d expected none", okind);
            end
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("strobe_kind", okind, e.kind);
               if (e.kind != 2) chk("read_data", {16'd0, odata}, {16'd0, e.data});
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      i_addr = '0; i_re = 1'b0;
      d_addr = '0; d_re = 1'b0; d_we = 1'b0; d_wdata = '0;
      for (int a = 0; a < 256; a++) mem[a] = 16'(a * 3);
      mem[4] = 16'hA5A5;
      tick();
      tick();
      chk("rst_m_re", {31'd0, m_re}, 32'd0);
      chk("rst_m_we", {31'd0, m_we}, 32'd0);
      chk("rst_i_rready", {31'd0, i_rready}, 32'd0);
      chk("rst_i_rdata", {16'd0, i_rdata}, 32'd0);
      rst = 1'b0;

      // Reset while a write to 0x0010 sits in ISSUE.
      d_we = 1'b1; d_addr = 16'h0010; d_wdata = 16'h5555;
      tick();
      chk("rst_issue_m_we", {31'd0, m_we}, 32'd1);
      chk("rst_issue_m_waddr", {16'd0, m_waddr}, 32'h0010);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_m_we", {31'd0, m_we}, 32'd0);
      chk("async_rst_m_waddr", {16'd0, m_waddr}, 32'd0);
      chk("async_rst_m_wdata", {16'd0, m_wdata}, 32'd0);
      chk("async_rst_d_wack", {31'd0, d_wack}, 32'd0);
      d_we = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      tick();
      chk("idle_no_m_re", {31'd0, m_re}, 32'd0);
      chk("idle_no_m_we", {31'd0, m_we}, 32'd0);

      // Fetch alone.
      i_re = 1'b1; i_addr = 16'h0004;
      push(0, 16'hA5A5);
      tick();
      chk("fetch_m_re", {31'd0, m_re}, 32'd1);
      chk("fetch_m_raddr", {16'd0, m_raddr}, 32'h0004);
      tick();
      chk("fetch_i_rready", {31'd0, i_rready}, 32'd1);
      i_re = 1'b0;
      tick();
      chk("fetch_pulse_single", {31'd0, i_rready}, 32'd0);

      // Store then load on 0x0020.
      d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
      push(2, 16'h0000);
      tick();
      chk("store_m_we", {31'd0, m_we}, 32'd1);
      chk("store_m_waddr", {16'd0, m_waddr}, 32'h0020);
      chk("store_m_wdata", {16'd0, m_wdata}, 32'h1234);
      tick();
      d_we = 1'b0;
      tick();
      d_re = 1'b1;
      push(1, 16'h1234);
      tick();
      chk("load_m_re", {31'd0, m_re}, 32'd1);
      chk("load_m_raddr", {16'd0, m_raddr}, 32'h0020);
      tick();
      d_re = 1'b0;
      tick();

      // Contention from reset release: both instances see identical traffic.
      rst = 1'b1;
      i_re = 1'b1; i_addr = 16'h0004;
      d_re = 1'b1; d_addr = 16'h0020;
      for (int k = 0; k < 8; k++) begin
         if (k % 2 == 0) push(0, 16'hA5A5);
         else push(1, 16'h1234);
      end
      tick();
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("rr_m_re", {31'd0, m_re}, 32'd1);
         chk("rr_m_raddr", {16'd0, m_raddr}, (k % 2 == 0) ? 32'h0004 : 32'h0020);
         chk("prio_m_re", {31'd0, p_m_re}, 32'd1);
         chk("prio_m_raddr", {16'd0, p_m_raddr}, (k % 2 == 0) ? 32'h0020 : 32'h0004);
         tick();
         if (k == 7) begin
            i_re = 1'b0;
            d_re = 1'b0;
         end
      end
      tick();
      chk("rr_drained_m_re", {31'd0, m_re}, 32'd0);

      // Dual data request on 0x0030: write first, then the read.
      d_we = 1'b1; d_re = 1'b1; d_addr = 16'h0030; d_wdata = 16'hBEEF;
      push(2, 16'h0000);
      push(1, 16'hBEEF);
      tick();
      chk("dual_m_we", {31'd0, m_we}, 32'd1);
      chk("dual_m_re_low", {31'd0, m_re}, 32'd0);
      chk("dual_m_waddr", {16'd0, m_waddr}, 32'h0030);
      tick();
      d_we = 1'b0;
      tick();
      tick();
      chk("dual_read_m_re", {31'd0, m_re}, 32'd1);
      chk("dual_read_m_raddr", {16'd0, m_raddr}, 32'h0030);
      tick();
      d_re = 1'b0;
      tick();
      tick();
      tick();
      chk("scoreboard_empty", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
